tag_queue_mp: RTL
=================

// Module: tag_queue_mp
// PURPOSE
//  In-order ring buffer of ROB/RS tags with multiple push and pop slots per cycle,
//  full/empty/occupancy status, flush, and a sticky misuse flag.
//  Sits between dispatch and the in-order consumers (CDB arbitration / commit ordering).
//  Used by the superscalar front end, where one push and one pop per cycle is insufficient.
// PARAMETERS
//  DEPTH      6  entries; any value >= 2 (non-power-of-2 legal, explicit wrap)
//  TAG_WIDTH  4  bits per tag
//  PUSH_W     2  max tags pushed per cycle, 1..DEPTH
//  POP_W      2  max tags popped per cycle, 1..DEPTH
// PORTS
//  clk          in   1                    clock, rising edge
//  reset        in   1                    async, active-low (0 = reset)
//  flush        in   1                    sync; empties queue (mispredict recovery)
//  push_cnt     in   $clog2(PUSH_W+1)     number of tags to push this cycle
//  push_tags    in   PUSH_W*TAG_WIDTH     slot 0 = bits [TAG_WIDTH-1:0], oldest first
//  push_accept  out  1                    comb: push group accepted this cycle
//  pop_cnt      in   $clog2(POP_W+1)      number of tags to pop this cycle
//  front_tags   out  POP_W*TAG_WIDTH      slot i = i-th oldest entry
//  front_valid  out  POP_W                bit i = 1 when i < count
//  count        out  $clog2(DEPTH+1)      occupancy
//  free_cnt     out  $clog2(DEPTH+1)      DEPTH - count
//  full, empty  out  1 each               count==DEPTH / count==0
//  err          out  1                    sticky: rejected push or over-pop seen
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): head=tail=0, count=0, all mem entries=0, err=0.
//    Outputs: empty=1, full=0, free_cnt=DEPTH, front_valid=0, front_tags=0, push_accept=0.
//  - Reset mid-operation: state clears immediately, without waiting for a clock edge.
//    No pending push/pop survives.
//  - Push is all-or-nothing: push_accept = reset & ~flush & (push_cnt<=PUSH_W)
//    & (push_cnt<=free_cnt).
//    free_cnt is the start-of-cycle value; slots freed by a same-cycle pop are not reusable.
//  - Accepted push: at the edge, mem[(tail+k)%DEPTH] <= push_tags slot k for k<push_cnt;
//    then tail += push_cnt (mod DEPTH).
//  - Rejected push with push_cnt>0: no state change from the push; err <= 1.
//  - Pop: eff_pop = min(pop_cnt, count); head += eff_pop (mod DEPTH).
//    If pop_cnt>count, err <= 1.
//  - count_next = count + accepted_push - eff_pop.
//    Push and pop in the same cycle are both applied.
//  - Latency: a pushed tag appears on front_tags the cycle after the edge. No bypass.
//    When empty, a push is not visible in the same cycle.
//  - front_tags slot i = mem[(head+i)%DEPTH] when i<count, else 0.
//    All front outputs derive combinationally from registers only.
//  - Flush (highest priority after reset): at the edge, head=tail=0 and count=0.
//    Push and pop in that cycle are ignored; err is unchanged; mem contents are don't-care.
//  - Wrap: pointer advance computes (ptr+n>=DEPTH) ? ptr+n-DEPTH : ptr+n.
//    n<=DEPTH is guaranteed. No % on non-power-of-2 values.
//  - Width rules: pointers are $clog2(DEPTH) bits. count/free_cnt are $clog2(DEPTH+1) bits.
//    Sums are computed one bit wider, then truncated after wrap.
//  - Tag contents are opaque; duplicates are legal.
// STRUCTURE
//  - tomasulo_pkg: TAG_WIDTH default localparam.
//    tomasulo_pkg: function wrap_add(ptr, n, depth) for ring pointer advance.
//    tomasulo_pkg: typedef tag_t.
//  - Single module with no sub-module: mem array, head/tail/count/err registers,
//    and a comb block for the accept, eff_pop and front-slot muxes.
//  - SVA in-file: count<=DEPTH; full&empty never both 1; tail==(head+count)%DEPTH.
// TESTING (DEPTH=6, TAG_WIDTH=4, PUSH_W=2, POP_W=2)
//  1. Hold reset=0 for 2 cycles, release.
//     -> empty=1, count=0, free_cnt=6, front_valid=00, front_tags=0, err=0.
//  2. push_cnt=2, tags {3,5}.
//     -> push_accept=1; next cycle count=2, front_tags={5,3} (slot0=3), front_valid=11.
//  3. Fill to 6 entries, then push_cnt=1.
//     -> full=1, push_accept=0, count stays 6, err=1 next cycle.
//  4. At count=5: push_cnt=2 + pop_cnt=2 -> push rejected (free=1), count=3.
//     At count=5: push_cnt=1 + pop_cnt=2 -> count=4.
//  5. Stream tags 0..15 in mixed 1/2 pushes and pops over 40 cycles.
//     -> pop order exactly 0..15 across multiple wraps; no loss or duplicate.
//  6. count=4, flush=1 with push_cnt=2 -> next cycle count=0, empty=1, front_valid=00.
//     Also: with count=4, drive reset=0 between edges -> count=0 immediately.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the out-of-order core's tag plumbing: the default tag
// width, the tag type, and the ring-pointer helper used by tag queues.
package tomasulo_pkg;

  localparam int unsigned TAG_WIDTH_DEF = 4;

  typedef logic [TAG_WIDTH_DEF-1:0] tag_t;

  // Advances a ring pointer by n slots, where n <= depth. The wrap is done by
  // subtraction, so depth does not need to be a power of two.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned n,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + n;
    return (sum >= depth) ? (sum - depth) : sum;
  endfunction

endpackage

// File: rtl/tag_queue_mp.sv
// In-order ring buffer of ROB/RS tags with up to PUSH_W pushes and POP_W pops
// per cycle, occupancy status, flush for mispredict recovery and a sticky misuse flag.
module tag_queue_mp
  import tomasulo_pkg::*;
#(
  parameter int unsigned DEPTH     = 6,
  parameter int unsigned TAG_WIDTH = TAG_WIDTH_DEF,
  parameter int unsigned PUSH_W    = 2,
  parameter int unsigned POP_W     = 2,
  localparam int unsigned PTR_W    = $clog2(DEPTH),
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1),
  localparam int unsigned PCNT_W   = $clog2(PUSH_W + 1),
  localparam int unsigned QCNT_W   = $clog2(POP_W + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [PCNT_W-1:0]         push_cnt,
  input  logic [PUSH_W*TAG_WIDTH-1:0] push_tags,
  output logic                      push_accept,
  input  logic [QCNT_W-1:0]         pop_cnt,
  output logic [POP_W*TAG_WIDTH-1:0] front_tags,
  output logic [POP_W-1:0]          front_valid,
  output logic [CNT_W-1:0]          count,
  output logic [CNT_W-1:0]          free_cnt,
  output logic                      full,
  output logic                      empty,
  output logic                      err
);

  typedef logic [TAG_WIDTH-1:0] slot_t;

  slot_t            mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  int unsigned push_n, pop_n, cnt_n, push_eff, pop_eff;

  // Accept/pop arithmetic is done in 32 bits and truncated once at the end, so
  // no intermediate sum can overflow the narrow count or pointer widths.
  always_comb begin
    push_n   = 32'(push_cnt);
    pop_n    = 32'(pop_cnt);
    cnt_n    = 32'(count_q);

    push_accept = reset && !flush && (push_n <= PUSH_W) && (push_n <= DEPTH - cnt_n);
    push_eff    = push_accept ? push_n : 0;
    pop_eff     = (pop_n < cnt_n) ? pop_n : cnt_n;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = err_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = PTR_W'(wrap_add(32'(head_q), pop_eff, DEPTH));
      tail_d  = PTR_W'(wrap_add(32'(tail_q), push_eff, DEPTH));
      count_d = CNT_W'(cnt_n + push_eff - pop_eff);
      if ((push_n != 0 && !push_accept) || (pop_n > cnt_n)) begin
        err_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed by the comb block above.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the storage array is cleared on reset here because front_tags must read
  // zero out of reset; a plain data RAM would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else if (push_accept) begin
      for (int unsigned k = 0; k < PUSH_W; k++) begin
        if (k < push_n) begin
          mem_q[PTR_W'(wrap_add(32'(tail_q), k, DEPTH))] <= push_tags[k*TAG_WIDTH +: TAG_WIDTH];
        end
      end
    end
  end

  // Front slots read registers only: a tag pushed this cycle is not visible until the next.
  always_comb begin
    front_tags  = '0;
    front_valid = '0;
    for (int unsigned i = 0; i < POP_W; i++) begin
      if (i < cnt_n) begin
        front_valid[i] = 1'b1;
        front_tags[i*TAG_WIDTH +: TAG_WIDTH] = mem_q[PTR_W'(wrap_add(32'(head_q), i, DEPTH))];
      end
    end
  end

  assign count    = count_q;
  assign free_cnt = CNT_W'(DEPTH) - count_q;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign err      = err_q;

  a_count_bound : assert property (@(posedge clk) disable iff (!reset)
    count_q <= CNT_W'(DEPTH));
  a_full_empty  : assert property (@(posedge clk) disable iff (!reset)
    !(full && empty));
  a_tail_track  : assert property (@(posedge clk) disable iff (!reset)
    32'(tail_q) == wrap_add(32'(head_q), 32'(count_q), DEPTH));

endmodule
